pong_vga_renderer: RTL and testbench
====================================

// Module: pong_vga_renderer
// PURPOSE
//  Consumes the game state (paddle Ys, ball X/Y, packed score) and produces 640x480@60 VGA sync and
//  2-bit-per-channel RGB. Sits directly downstream of the pong game logic, in front of the TinyVGA pins.
//  Samples game state once per frame at vblank start, and gives the game logic a frame-tick for stepping.
// PARAMETERS
//  H_ACTIVE 640 / H_FP 16 / H_SYNC 96 / H_BP 48 : horizontal timing, pixels (total 800)
//  V_ACTIVE 480 / V_FP 10 / V_SYNC 2  / V_BP 33 : vertical timing, lines (total 525)
//  PADDLE_W 10, PADDLE_H 60, BALL_SIZE 10       : sprite sizes, pixels
//  PADDLE_X 8                                   : player paddle left edge; opponent left edge = H_ACTIVE-PADDLE_X-PADDLE_W
// PORTS
//  clk          in   1   pixel clock (25.175 MHz nominal)
//  rst_n        in   1   synchronous, active-low reset
//  player_y     in   10  player paddle top edge
//  opponent_y   in   10  opponent paddle top edge
//  ball_x       in   10  ball left edge
//  ball_y       in   10  ball top edge
//  score        in   8   [7:4] opponent, [3:0] player
//  hsync        out  1   active-low horizontal sync
//  vsync        out  1   active-low vertical sync
//  rgb          out  6   {R[1:0],G[1:0],B[1:0]}
//  frame_tick   out  1   1-cycle pulse, first cycle of vblank
// BEHAVIOUR
//  - Reset: h_cnt=0, v_cnt=0, hsync=1, vsync=1, rgb=0, frame_tick=0; snapshot = ball(320,240), paddles 210, score 0.
//  - h_cnt 0..799 wraps to 0; at wrap v_cnt increments, 524 wraps to 0. Counter widths are 10 bits each.
//  - Sync, combinational decode: hsync low for h in [656,751]; vsync low for v in [490,491].
//  - All outputs registered: hsync/vsync/rgb lag the counter by exactly 1 clk, with equal lag (no skew).
//  - Snapshot: when h_cnt==0 && v_cnt==480, latch all five game-state inputs. frame_tick goes high the next cycle, for 1 cycle.
//    The snapshot is held constant for the whole next active frame (no tearing).
//  - Draw with 11-bit compares so that y+PADDLE_H / x+BALL_SIZE never wrap. Region hit when left<=h<left+W && top<=v<top+H.
//    Sprites extending past 639/479 are clipped; no wrap-around drawing.
//  - Priority: ball (white 111111) > paddles (player 001111 cyan, opponent 110011 magenta) > score (111111) > centre net > bg 000000.
//  - Centre net: h in [318,321] && v[4]==0, colour 010101.
//  - rgb forced 000000 whenever h>=640 or v>=480 (blanking).
//  - rst_n low mid-frame: all state returns to reset values on the next edge; first frame after release is full-length.
// CONFIGURATION
//  PONG_SCORE_DIGITS_EN defined: two 7-segment hex digits, each 20x32 px, segment thickness 4 px.
//    Player digit (score[3:0]) drawn at x=280,y=16; opponent digit (score[7:4]) drawn at x=340,y=16. Values 0-F.
//  Not defined: no digit logic is built, score input is unused (tied to an _unused reduction), and the snapshot has no score register.
// STRUCTURE
//  pong_pkg: timing constants, sprite sizes, colour localparams, reset-position constants.
//  Sub-module vga_timing: h/v counters, sync decode, in_active flag, vblank-start strobe.
//  Top level holds: snapshot registers, region compare, priority mux, output registers, and the optional seven_seg glyph decode (function).
// TESTING
//  1 Reset, run 2 frames -> hsync period 800 clk, low 96 clk; vsync period 420000 clk, low 1600 clk; rgb=0 in blanking.
//  2 ball=(100,50), paddles 0/420, sampled at vblank -> pixel(100,50) and (109,59) white; (110,50) is bg; (8,0) cyan; (622,479) magenta.
//  3 Change ball_x mid-active-frame -> image unchanged until after next frame_tick; frame_tick pulses once per 420000 clk.
//  4 player_y=470 -> paddle drawn for rows 470..479 only; no pixels on rows 0..49 (no wrap).
//  5 Ball overlapping paddle at (10,100) -> overlap pixels white (priority); net pixel (319,0) 010101, (319,16) bg.
//  6 PONG_SCORE_DIGITS_EN, score=8'h3A -> segments of "A" at x=280, "3" at x=340; build without macro -> those pixels bg.
//  7 rst_n low for 3 clk at h=300,v=200 -> hsync=vsync=1, rgb=0; count restarts at (0,0).

Source files
------------

// File: rtl/pong_vga_renderer_pkg.sv
// pong_vga_renderer_pkg: VGA timing, sprite geometry, colours and reset snapshot for the pong renderer.
package pong_vga_renderer_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int PADDLE_W = 10;
  localparam int PADDLE_H = 60;
  localparam int BALL_SIZE = 10;
  localparam int PADDLE_X = 8;
  localparam int DIGIT_W = 20;
  localparam int DIGIT_H = 32;
  localparam int DIGIT_Y = 16;
  localparam int SEG_T = 4;
  localparam int RST_BALL_X = 320;
  localparam int RST_BALL_Y = 240;
  localparam int RST_PADDLE_Y = 210;
  localparam logic [5:0] C_BG = 6'b000000;
  localparam logic [5:0] C_WHITE = 6'b111111;
  localparam logic [5:0] C_CYAN = 6'b001111;
  localparam logic [5:0] C_MAGENTA = 6'b110011;
  localparam logic [5:0] C_NET = 6'b010101;

  typedef struct packed {
    logic [9:0] player_y;
    logic [9:0] opponent_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
  } snap_t;

  localparam snap_t SNAP_RST = '{
    player_y: 10'(RST_PADDLE_Y),
    opponent_y: 10'(RST_PADDLE_Y),
    ball_x: 10'(RST_BALL_X),
    ball_y: 10'(RST_BALL_Y)
  };

  // 11-bit operands so top+size can never wrap back onto the screen
  function automatic logic in_rect(input logic [10:0] h, v, x, y, w, ht);
    return h >= x && h < x + w && v >= y && v < y + ht;
  endfunction
endpackage

// File: rtl/pong_vga_renderer_if.sv
// pong_vga_renderer_if: game-state inputs and VGA outputs between pong logic (master) and renderer (slave).
interface pong_vga_renderer_if;
  logic [9:0] player_y;
  logic [9:0] opponent_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [7:0] score;
  logic hsync;
  logic vsync;
  logic [5:0] rgb;
  logic frame_tick;

  modport master (
    output player_y, opponent_y, ball_x, ball_y, score,
    input hsync, vsync, rgb, frame_tick
  );

  modport slave (
    input player_y, opponent_y, ball_x, ball_y, score,
    output hsync, vsync, rgb, frame_tick
  );
endinterface

// File: rtl/pong_vga_renderer_timing.sv
// pong_vga_renderer_timing: h/v pixel counters, combinational sync decode, active flag and vblank-start strobe.
module pong_vga_renderer_timing
  import pong_vga_renderer_pkg::*;
#(
  parameter int P_H_ACTIVE = H_ACTIVE,
  parameter int P_H_FP = H_FP,
  parameter int P_H_SYNC = H_SYNC,
  parameter int P_H_BP = H_BP,
  parameter int P_V_ACTIVE = V_ACTIVE,
  parameter int P_V_FP = V_FP,
  parameter int P_V_SYNC = V_SYNC,
  parameter int P_V_BP = V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] o_h,
  output logic [9:0] o_v,
  output logic       o_hsync_n,
  output logic       o_vsync_n,
  output logic       o_active,
  output logic       o_vblank_start
);
  localparam logic [9:0] H_LAST = 10'(P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP - 1);
  localparam logic [9:0] HS_START = 10'(P_H_ACTIVE + P_H_FP);
  localparam logic [9:0] HS_END = 10'(P_H_ACTIVE + P_H_FP + P_H_SYNC);
  localparam logic [9:0] VS_START = 10'(P_V_ACTIVE + P_V_FP);
  localparam logic [9:0] VS_END = 10'(P_V_ACTIVE + P_V_FP + P_V_SYNC);

  logic [9:0] r_h;
  logic [9:0] r_v;
  logic w_h_last;
  logic w_v_last;

  assign w_h_last = r_h == H_LAST;
  assign w_v_last = r_v == V_LAST;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= w_h_last ? '0 : r_h + 10'd1;
      if (w_h_last) r_v <= w_v_last ? '0 : r_v + 10'd1;
    end
  end

  assign o_h = r_h;
  assign o_v = r_v;
  assign o_hsync_n = !(r_h >= HS_START && r_h < HS_END);
  assign o_vsync_n = !(r_v >= VS_START && r_v < VS_END);
  assign o_active = r_h < 10'(P_H_ACTIVE) && r_v < 10'(P_V_ACTIVE);
  assign o_vblank_start = r_h == '0 && r_v == 10'(P_V_ACTIVE);
endmodule

// File: rtl/pong_vga_renderer.sv
// pong_vga_renderer: per-frame game-state snapshot, sprite compare, priority mux and registered VGA outputs.
// Optional score digits are built only when PONG_SCORE_DIGITS_EN is defined.
module pong_vga_renderer
  import pong_vga_renderer_pkg::*;
#(
  parameter int P_H_ACTIVE = H_ACTIVE,
  parameter int P_H_FP = H_FP,
  parameter int P_H_SYNC = H_SYNC,
  parameter int P_H_BP = H_BP,
  parameter int P_V_ACTIVE = V_ACTIVE,
  parameter int P_V_FP = V_FP,
  parameter int P_V_SYNC = V_SYNC,
  parameter int P_V_BP = V_BP
) (
  input  logic clk,
  input  logic rst_n,
  pong_vga_renderer_if.slave io_pong
);
  localparam logic [10:0] OPP_X = 11'(P_H_ACTIVE - PADDLE_X - PADDLE_W);
  localparam logic [9:0] NET_L = 10'(P_H_ACTIVE / 2 - 2);
  localparam logic [9:0] NET_R = 10'(P_H_ACTIVE / 2 + 1);

  logic [9:0] w_h;
  logic [9:0] w_v;
  logic w_hsync_n;
  logic w_vsync_n;
  logic w_active;
  logic w_vblank_start;
  logic [10:0] w_h11;
  logic [10:0] w_v11;
  logic w_ball;
  logic w_player;
  logic w_opp;
  logic w_score;
  logic w_net;
  logic [5:0] w_pix;

  snap_t r_snap;
  logic r_hsync;
  logic r_vsync;
  logic [5:0] r_rgb;
  logic r_tick;

  pong_vga_renderer_timing #(
    .P_H_ACTIVE(P_H_ACTIVE), .P_H_FP(P_H_FP), .P_H_SYNC(P_H_SYNC), .P_H_BP(P_H_BP),
    .P_V_ACTIVE(P_V_ACTIVE), .P_V_FP(P_V_FP), .P_V_SYNC(P_V_SYNC), .P_V_BP(P_V_BP)
  ) u_timing (
    .clk(clk),
    .rst_n(rst_n),
    .o_h(w_h),
    .o_v(w_v),
    .o_hsync_n(w_hsync_n),
    .o_vsync_n(w_vsync_n),
    .o_active(w_active),
    .o_vblank_start(w_vblank_start)
  );

  assign w_h11 = {1'b0, w_h};
  assign w_v11 = {1'b0, w_v};

`ifdef PONG_SCORE_DIGITS_EN
  localparam logic [10:0] DP_X = 11'(P_H_ACTIVE / 2 - 40);
  localparam logic [10:0] DO_X = 11'(P_H_ACTIVE / 2 + 20);
  localparam logic [10:0] DY = 11'(DIGIT_Y);
  localparam logic [10:0] DW = 11'(DIGIT_W);
  localparam logic [10:0] DH = 11'(DIGIT_H);
  localparam logic [10:0] ST = 11'(SEG_T);
  // segment order {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  logic [7:0] r_score;

  function automatic logic [6:0] seven_seg(input logic [3:0] n);
    return SEG_LUT[n];
  endfunction

  function automatic logic digit_hit(input logic [3:0] n, input logic [10:0] h, v, x);
    logic [6:0] s;
    logic [10:0] lx;
    logic [10:0] ly;
    s = seven_seg(n);
    lx = h - x;
    ly = v - DY;
    return in_rect(h, v, x, DY, DW, DH) && (
      (s[6] && ly < ST) ||
      (s[5] && lx >= DW - ST && ly < DH / 2) ||
      (s[4] && lx >= DW - ST && ly >= DH / 2) ||
      (s[3] && ly >= DH - ST) ||
      (s[2] && lx < ST && ly >= DH / 2) ||
      (s[1] && lx < ST && ly < DH / 2) ||
      (s[0] && ly >= DH / 2 - ST / 2 && ly < DH / 2 + ST / 2));
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) r_score <= '0;
    else if (w_vblank_start) r_score <= io_pong.score;
  end

  assign w_score = digit_hit(r_score[3:0], w_h11, w_v11, DP_X) ||
                   digit_hit(r_score[7:4], w_h11, w_v11, DO_X);
`else
  logic w_unused;

  assign w_unused = ^io_pong.score;
  assign w_score = 1'b0;
`endif

  assign w_ball = in_rect(w_h11, w_v11, {1'b0, r_snap.ball_x}, {1'b0, r_snap.ball_y},
                          11'(BALL_SIZE), 11'(BALL_SIZE));
  assign w_player = in_rect(w_h11, w_v11, 11'(PADDLE_X), {1'b0, r_snap.player_y},
                            11'(PADDLE_W), 11'(PADDLE_H));
  assign w_opp = in_rect(w_h11, w_v11, OPP_X, {1'b0, r_snap.opponent_y},
                         11'(PADDLE_W), 11'(PADDLE_H));
  assign w_net = w_h >= NET_L && w_h <= NET_R && !w_v[4];

  always_comb begin
    w_pix = !w_active ? C_BG :
            w_ball    ? C_WHITE :
            w_player  ? C_CYAN :
            w_opp     ? C_MAGENTA :
            w_score   ? C_WHITE :
            w_net     ? C_NET : C_BG;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_snap <= SNAP_RST;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_rgb <= C_BG;
      r_tick <= 1'b0;
    end else begin
      if (w_vblank_start)
        r_snap <= {io_pong.player_y, io_pong.opponent_y, io_pong.ball_x, io_pong.ball_y};
      r_hsync <= w_hsync_n;
      r_vsync <= w_vsync_n;
      r_rgb <= w_pix;
      r_tick <= w_vblank_start;
    end
  end

  assign io_pong.hsync = r_hsync;
  assign io_pong.vsync = r_vsync;
  assign io_pong.rgb = r_rgb;
  assign io_pong.frame_tick = r_tick;
endmodule

// File: tb/tb_pong_vga_renderer.sv
// tb_pong_vga_renderer: scaled-geometry run checking sync, frame_tick and every pixel against a frame model.
module tb_pong_vga_renderer;
  localparam int HA = 128, HF = 4, HS = 8, HB = 4;
  localparam int VA = 80, VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int N = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int k = 0;
  int sp, so, sbx, sby, ssc;
  logic e_hs, e_vs, e_ft;
  logic [5:0] e_rgb;
  int seg_mask [16] = '{'h7E, 'h30, 'h6D, 'h79, 'h33, 'h5B, 'h5F, 'h70,
                        'h7F, 'h7B, 'h77, 'h1F, 'h4E, 'h3D, 'h4F, 'h47};
  int seg_x [7] = '{0, 16, 16, 0, 0, 0, 0};
  int seg_y [7] = '{0, 0, 16, 28, 16, 0, 14};
  int seg_w [7] = '{20, 4, 4, 20, 4, 4, 20};
  int seg_h [7] = '{4, 16, 16, 4, 16, 16, 4};

  pong_vga_renderer_if io ();

  pong_vga_renderer #(
    .P_H_ACTIVE(HA), .P_H_FP(HF), .P_H_SYNC(HS), .P_H_BP(HB),
    .P_V_ACTIVE(VA), .P_V_FP(VF), .P_V_SYNC(VS), .P_V_BP(VB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io_pong(io.slave)
  );

  always #5 clk = ~clk;

  function automatic bit inr(int h, int v, int x, int y, int w, int ht);
    return h >= x && h < x + w && v >= y && v < y + ht;
  endfunction

  function automatic bit digit(int x, int y, int n);
    bit hit = 0;
    if (!inr(x, y, 0, 0, 20, 32)) return 0;
    for (int s = 0; s < 7; s++)
      if (seg_mask[n][6-s] && inr(x, y, seg_x[s], seg_y[s], seg_w[s], seg_h[s])) hit = 1;
    return hit;
  endfunction

  function automatic logic [5:0] pix(int h, int v);
    if (h >= HA || v >= VA) return 6'b000000;
    if (inr(h, v, sbx, sby, 10, 10)) return 6'b111111;
    if (inr(h, v, 8, sp, 10, 60)) return 6'b001111;
    if (inr(h, v, HA - 18, so, 10, 60)) return 6'b110011;
`ifdef PONG_SCORE_DIGITS_EN
    if (digit(h - (HA / 2 - 40), v - 16, ssc % 16) || digit(h - (HA / 2 + 20), v - 16, ssc / 16))
      return 6'b111111;
`endif
    if (h >= HA / 2 - 2 && h <= HA / 2 + 1 && (v % 32) < 16) return 6'b010101;
    return 6'b000000;
  endfunction

  task automatic snap_reset();
    sbx = 320; sby = 240; sp = 210; so = 210; ssc = 0;
  endtask

  task automatic adv(input bit in_rst);
    int c, h, v;
    c = k % N;
    h = c % HT;
    v = c / HT;
    if (in_rst) begin
      e_hs = 1; e_vs = 1; e_rgb = 0; e_ft = 0;
    end else begin
      e_rgb = pix(h, v);
      e_hs = !(h >= HA + HF && h < HA + HF + HS);
      e_vs = !(v >= VA + VF && v < VA + VF + VS);
      e_ft = c == VA * HT;
      if (c == VA * HT) begin
        sp = int'(io.player_y); so = int'(io.opponent_y);
        sbx = int'(io.ball_x); sby = int'(io.ball_y); ssc = int'(io.score);
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (in_rst) begin
      k = 0;
      snap_reset();
    end else k++;
    vectors++;
    assert (io.rgb === e_rgb) else begin
      miscompares++;
      $error("FAIL rgb h=%0d v=%0d rst=%0d got %b exp %b", h, v, in_rst, io.rgb, e_rgb);
    end
    assert (io.hsync === e_hs) else begin
      miscompares++;
      $error("FAIL hsync h=%0d v=%0d got %b exp %b", h, v, io.hsync, e_hs);
    end
    assert (io.vsync === e_vs) else begin
      miscompares++;
      $error("FAIL vsync h=%0d v=%0d got %b exp %b", h, v, io.vsync, e_vs);
    end
    assert (io.frame_tick === e_ft) else begin
      miscompares++;
      $error("FAIL frame_tick h=%0d v=%0d got %b exp %b", h, v, io.frame_tick, e_ft);
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) adv(0);
  endtask

  function automatic logic [9:0] rpos();
    return ($urandom_range(0, 7) == 0) ? 10'(1023 - $urandom_range(0, 15))
                                       : 10'($urandom_range(0, 140));
  endfunction

  task automatic shuffle_inputs();
    io.player_y = rpos(); io.opponent_y = rpos();
    io.ball_x = rpos(); io.ball_y = rpos();
    io.score = 8'($urandom);
  endtask

  initial begin
    snap_reset();
    io.player_y = 10'd0; io.opponent_y = 10'd20;
    io.ball_x = 10'd30; io.ball_y = 10'd20; io.score = 8'h3A;
    rst_n = 1'b0;
    repeat (3) adv(1);
    rst_n = 1'b1;
    run(N);
    run(N / 2);
    io.ball_x = 10'($urandom_range(0, 120));
    run(N - N / 2);
    io.player_y = 10'd1000; io.opponent_y = 10'(VA - 10);
    io.ball_x = 10'd1020; io.ball_y = 10'd1020;
    run(N);
    io.player_y = 10'd30; io.ball_x = 10'd10; io.ball_y = 10'd40; io.score = 8'h3A;
    run(N + 30 * HT + 60);
    rst_n = 1'b0;
    repeat (3) adv(1);
    rst_n = 1'b1;
    for (int r = 0; r < 6; r++) begin
      shuffle_inputs();
      run(N / 4);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
